// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding mux selects,
// stall FSM states and a constant-evaluable ceil(log2) helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2
    } hz_state_t;

    function automatic int hz_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_fwd_port.sv
// One read port's forwarding priority encoder plus its load-use hit flag.
// Register 0 never forwards and never raises a load-use hit.
module hazard_fwd_port
    import hazard_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic            rs_used,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_wreg,
    input  logic            mem_regwrite,
    input  logic [REGW-1:0] mem_wreg,
    input  logic            wb_regwrite,
    input  logic [REGW-1:0] wb_wreg,
    output logic [1:0]      fwd_sel,
    output logic            lu_hit
);

    logic live_read;

    assign live_read = rs_used && (rs != '0);

    always_comb begin
        fwd_sel = FWD_RF;
        if (live_read) begin
            // A load in EX has no result yet, so it falls through to older stages.
            if (ex_regwrite && !ex_memread && (ex_wreg == rs)) begin
                fwd_sel = FWD_EX;
            end else if (mem_regwrite && (mem_wreg == rs)) begin
                fwd_sel = FWD_MEM;
            end else if (wb_regwrite && (wb_wreg == rs)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

    assign lu_hit = live_read && ex_regwrite && ex_memread && (ex_wreg == rs);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: per-port forwarding selection and a stall FSM
// covering multi-cycle load-use stalls and post-branch flush bubbles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREAD        = 2,
    parameter int REGW         = 5,
    parameter int LOAD_USE_CYC = 1,
    parameter int BR_BUBBLES   = 1,
    parameter int CNTW         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    dmem_wait,
    input  logic                    imem_wait,
    input  logic [NREAD*REGW-1:0]   id_rs,
    input  logic [NREAD-1:0]        id_rs_used,
    input  logic                    id_branch,
    input  logic                    ex_regwrite,
    input  logic                    ex_memread,
    input  logic [REGW-1:0]         ex_wreg,
    input  logic                    mem_regwrite,
    input  logic [REGW-1:0]         mem_wreg,
    input  logic                    wb_regwrite,
    input  logic [REGW-1:0]         wb_wreg,
    output logic                    pc_write,
    output logic                    ifid_write,
    output logic                    bubble,
    output logic                    pipe_en,
    output logic                    imem_en,
    output logic [2*NREAD-1:0]      fwd_sel,
    output logic [CNTW-1:0]         stall_count
);

    localparam int MAX_BUB = (LOAD_USE_CYC > BR_BUBBLES) ? LOAD_USE_CYC : BR_BUBBLES;
    localparam int CW      = hz_clog2(MAX_BUB) + 1;
    localparam logic [CW-1:0] LU_RELOAD = CW'(LOAD_USE_CYC - 1);
    localparam logic [CW-1:0] BR_RELOAD = CW'(BR_BUBBLES - 1);

    hz_state_t         state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [CNTW-1:0]   stall_count_reg;

    logic [NREAD-1:0]   lu_hit;
    logic [2*NREAD-1:0] fwd_raw;
    logic               lu;
    logic               mem_wait;
    logic               run_ok;
    logic               advance;
    logic               st_bubble;
    logic               st_pc;
    logic               st_ifid;
    logic               st_imem;

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
            hazard_fwd_port #(
                .REGW(REGW)
            ) u_fwd (
                .rs           (id_rs[gi*REGW +: REGW]),
                .rs_used      (id_rs_used[gi]),
                .ex_regwrite  (ex_regwrite),
                .ex_memread   (ex_memread),
                .ex_wreg      (ex_wreg),
                .mem_regwrite (mem_regwrite),
                .mem_wreg     (mem_wreg),
                .wb_regwrite  (wb_regwrite),
                .wb_wreg      (wb_wreg),
                .fwd_sel      (fwd_raw[2*gi +: 2]),
                .lu_hit       (lu_hit[gi])
            );
        end
    endgenerate

    assign lu       = |lu_hit;
    assign mem_wait = dmem_wait | imem_wait;
    assign run_ok   = rst & enable;
    assign advance  = enable & ~mem_wait;

    // Outputs implied by the FSM alone, before run/wait gating.
    always_comb begin
        st_bubble = 1'b0;
        st_pc     = 1'b1;
        st_ifid   = 1'b1;
        st_imem   = 1'b1;
        case (state_reg)
            ST_RUN: begin
                if (lu) begin
                    st_bubble = 1'b1;
                    st_pc     = 1'b0;
                    st_ifid   = 1'b0;
                    st_imem   = 1'b0;
                end else if (id_branch) begin
                    st_bubble = 1'b1;
                    st_ifid   = 1'b0;
                end
            end
            default: begin
                st_bubble = 1'b1;
                st_pc     = 1'b0;
                st_ifid   = 1'b0;
                st_imem   = 1'b0;
            end
        endcase
    end

    assign pipe_en     = run_ok & ~mem_wait;
    assign pc_write    = pipe_en & st_pc;
    assign ifid_write  = pipe_en & st_ifid;
    assign imem_en     = run_ok & ~dmem_wait & st_imem;
    assign bubble      = run_ok & st_bubble;
    assign fwd_sel     = rst ? fwd_raw : '0;
    assign stall_count = stall_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_RUN;
            cnt_reg         <= '0;
            stall_count_reg <= '0;
        end else if (advance) begin
            if (st_bubble && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            case (state_reg)
                ST_RUN: begin
                    if (lu) begin
                        if (LOAD_USE_CYC > 1) begin
                            state_reg <= ST_LU_STALL;
                            cnt_reg   <= LU_RELOAD;
                        end
                    end else if (id_branch) begin
                        if (BR_BUBBLES > 1) begin
                            state_reg <= ST_BR_FLUSH;
                            cnt_reg   <= BR_RELOAD;
                        end
                    end
                end
                ST_LU_STALL, ST_BR_FLUSH: begin
                    // cnt holds the bubbles still owed including this one.
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= ST_RUN;
                    end
                    cnt_reg <= cnt_reg - 1'b1;
                end
                default: begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a bubble-count model.
module tb_hazard_ctrl;

    localparam int NREAD   = 2;
    localparam int REGW    = 5;
    localparam int LU_CYC  = 2;
    localparam int BR_BUB  = 2;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic                  dmem_wait;
    logic                  imem_wait;
    logic [NREAD*REGW-1:0] id_rs;
    logic [NREAD-1:0]      id_rs_used;
    logic                  id_branch;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [REGW-1:0]       ex_wreg;
    logic                  mem_regwrite;
    logic [REGW-1:0]       mem_wreg;
    logic                  wb_regwrite;
    logic [REGW-1:0]       wb_wreg;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  bubble;
    logic                  pipe_en;
    logic                  imem_en;
    logic [2*NREAD-1:0]    fwd_sel;
    logic [CNTW-1:0]       stall_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_rem  = 0;
    int m_cnt  = 0;
    int sc0;

    logic              last_bubble;
    logic              last_pc;
    logic              last_pipe;
    logic              last_imem;
    logic [2*NREAD-1:0] last_fwd;

    hazard_ctrl #(
        .NREAD(NREAD), .REGW(REGW), .LOAD_USE_CYC(LU_CYC),
        .BR_BUBBLES(BR_BUB), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .dmem_wait(dmem_wait), .imem_wait(imem_wait),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_branch(id_branch),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
        .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
        .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
        .pc_write(pc_write), .ifid_write(ifid_write), .bubble(bubble),
        .pipe_en(pipe_en), .imem_en(imem_en), .fwd_sel(fwd_sel),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input int k);
        logic [REGW-1:0] r;
        r = id_rs[k*REGW +: REGW];
        if (!id_rs_used[k] || r == 0) return 2'd0;
        if (ex_regwrite && !ex_memread && ex_wreg == r) return 2'd1;
        if (mem_regwrite && mem_wreg == r) return 2'd2;
        if (wb_regwrite && wb_wreg == r) return 2'd3;
        return 2'd0;
    endfunction

    // Model: m_rem = bubbles still owed after the current one.
    task automatic tick();
        logic lu, wt, act;
        logic e_bub, e_pc, e_ifid, e_im, e_pipe;
        logic [2*NREAD-1:0] e_fwd;
        @(negedge clk);
        if (!rst) begin
            m_rem = 0;
            m_cnt = 0;
        end
        lu = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            if (id_rs_used[k] && ex_regwrite && ex_memread && ex_wreg != 0 &&
                id_rs[k*REGW +: REGW] == ex_wreg) lu = 1'b1;
            e_fwd[2*k +: 2] = rst ? m_fwd(k) : 2'd0;
        end
        if (m_rem > 0 || lu) begin
            e_bub = 1; e_pc = 0; e_ifid = 0; e_im = 0;
        end else if (id_branch) begin
            e_bub = 1; e_pc = 1; e_ifid = 0; e_im = 1;
        end else begin
            e_bub = 0; e_pc = 1; e_ifid = 1; e_im = 1;
        end
        act = rst && enable;
        wt  = dmem_wait || imem_wait;
        e_pipe = act && !wt;
        if (!act) begin
            e_bub = 0; e_pc = 0; e_ifid = 0; e_im = 0;
        end else if (wt) begin
            e_pc = 0; e_ifid = 0;
            if (dmem_wait) e_im = 0;
        end
        chk("pc_write", pc_write, e_pc);
        chk("ifid_write", ifid_write, e_ifid);
        chk("bubble", bubble, e_bub);
        chk("pipe_en", pipe_en, e_pipe);
        chk("imem_en", imem_en, e_im);
        chk("fwd_sel", fwd_sel, e_fwd);
        chk("stall_count", stall_count, m_cnt);
        $display("cyc=%0d rst=%b en=%b dw=%b iw=%b br=%b lu=%b -> pc=%b ifid=%b bub=%b pipe=%b im=%b fwd=%h sc=%0d",
                 cyc, rst, enable, dmem_wait, imem_wait, id_branch, lu,
                 pc_write, ifid_write, bubble, pipe_en, imem_en, fwd_sel, stall_count);
        last_bubble = bubble;
        last_pc     = pc_write;
        last_pipe   = pipe_en;
        last_imem   = imem_en;
        last_fwd    = fwd_sel;
        if (act && !wt) begin
            if (e_bub && m_cnt < CNT_MAX) m_cnt++;
            if (m_rem > 0) m_rem--;
            else if (lu) m_rem = LU_CYC - 1;
            else if (id_branch) m_rem = BR_BUB - 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_ex();
        ex_regwrite = 0; ex_memread = 0; ex_wreg = 0;
        mem_regwrite = 0; mem_wreg = 0; wb_regwrite = 0; wb_wreg = 0;
    endtask

    task automatic set_load_use();
        ex_regwrite = 1; ex_memread = 1; ex_wreg = 5'd5;
        id_rs_used = 2'b10; id_rs = {5'd5, 5'd0};
    endtask

    initial begin
        rst = 0; enable = 1; dmem_wait = 0; imem_wait = 0;
        id_rs = '0; id_rs_used = '0; id_branch = 0;
        clear_ex();
        #1;
        tick();
        tick();
        chk("reset_stall_count", stall_count, 0);
        rst = 1;
        tick();

        // Forwarding priority on port 0.
        id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        ex_regwrite = 1; ex_wreg = 5'd3; mem_regwrite = 1; mem_wreg = 5'd3;
        wb_regwrite = 1; wb_wreg = 5'd3;
        tick(); chk("t1_fwd_ex", last_fwd[1:0], 1);
        ex_regwrite = 0;
        tick(); chk("t1_fwd_mem", last_fwd[1:0], 2);
        mem_regwrite = 0;
        tick(); chk("t1_fwd_wb", last_fwd[1:0], 3);
        id_rs = '0; ex_regwrite = 1; ex_wreg = 0; mem_regwrite = 1; mem_wreg = 0; wb_wreg = 0;
        tick(); chk("t1_fwd_r0", last_fwd[1:0], 0);
        clear_ex(); id_rs_used = '0;

        // Two-cycle load-use stall.
        sc0 = int'(stall_count);
        set_load_use();
        tick(); chk("t2_c1_bubble", last_bubble, 1); chk("t2_c1_pc", last_pc, 0);
        clear_ex();
        tick(); chk("t2_c2_bubble", last_bubble, 1); chk("t2_c2_pc", last_pc, 0);
        tick(); chk("t2_c3_bubble", last_bubble, 0);
        chk("t2_count", stall_count, sc0 + 2);

        // Branch flush.
        id_branch = 1;
        tick(); chk("t3_c1_pc", last_pc, 1); chk("t3_c1_imem", last_imem, 1);
        id_branch = 0;
        tick(); chk("t3_c2_bubble", last_bubble, 1); chk("t3_c2_pc", last_pc, 0);
        tick(); chk("t3_c3_bubble", last_bubble, 0);

        // Load-use beats branch; branch follows the stall.
        set_load_use(); id_branch = 1;
        tick(); chk("t4_c1_pc", last_pc, 0);
        clear_ex();
        tick();
        tick(); chk("t4_c3_pc", last_pc, 1); chk("t4_c3_bubble", last_bubble, 1);
        id_branch = 0;
        tick();
        tick(); chk("t4_c5_bubble", last_bubble, 0);

        // dmem_wait in the middle of a load-use stall.
        sc0 = int'(stall_count);
        set_load_use();
        tick();
        clear_ex(); dmem_wait = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t5_wait_pipe", last_pipe, 0); chk("t5_wait_imem", last_imem, 0);
        end
        dmem_wait = 0;
        tick(); chk("t5_resume_bubble", last_bubble, 1);
        tick(); chk("t5_done_bubble", last_bubble, 0);
        chk("t5_count", stall_count, sc0 + 2);

        // Reset in the middle of a branch flush.
        id_branch = 1;
        tick();
        id_branch = 0;
        rst = 0;
        #1;
        chk("t6_bubble", bubble, 0);
        chk("t6_pipe_en", pipe_en, 0);
        chk("t6_stall_count", stall_count, 0);
        tick();
        rst = 1;
        tick(); chk("t6_run_bubble", last_bubble, 0); chk("t6_run_pc", last_pc, 1);

        // Random traffic, including saturation of the narrow counter.
        for (int n = 0; n < 500; n++) begin
            rst          = ($urandom_range(0, 99) != 0);
            enable       = ($urandom_range(0, 9) != 0);
            dmem_wait    = ($urandom_range(0, 7) == 0);
            imem_wait    = ($urandom_range(0, 7) == 0);
            id_branch    = ($urandom_range(0, 4) == 0);
            id_rs_used   = 2'($urandom_range(0, 3));
            for (int k = 0; k < NREAD; k++) id_rs[k*REGW +: REGW] = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 2) == 0);
            ex_wreg      = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_wreg     = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_wreg      = 5'($urandom_range(0, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor of the mMips combinational hazard unit: per-read-port forwarding selection plus a sequential stall controller.
- Sits beside the ID stage. Consumes destination info from the ID/EX, EX/MEM and MEM/WB pipeline registers plus the memory wait lines.
- Drives PC write, IF/ID write, bubble insertion, pipeline enable, imem enable and the forwarding muxes.
- Adds behaviour the previous unit lacked: multi-cycle load-use stalls, configurable branch bubbles, register-0 exclusion on every path, and a saturating stall-cycle counter.

Parameters:
- NREAD, 2: number of ID-stage register read ports.
- REGW, 5: register index width.
- LOAD_USE_CYC, 1: bubbles inserted on a load-use hazard (>=1).
- BR_BUBBLES, 1: bubbles inserted after a taken/decoded branch (>=1).
- CNTW, 16: stall counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  global run enable.
- dmem_wait  in  1  data memory busy.
- imem_wait  in  1  instruction memory busy.
- id_rs  in  NREAD*REGW  read register indices, port k at [k*REGW +: REGW].
- id_rs_used  in  NREAD  port k actually reads a register.
- id_branch  in  1  ID instruction is a branch/jump (BranchOpID != 0).
- ex_regwrite  in  1  ID/EX RegWrite.
- ex_memread  in  1  ID/EX instruction is a load.
- ex_wreg  in  REGW  ID/EX resolved destination (RegDst already applied).
- mem_regwrite  in  1  EX/MEM RegWrite.
- mem_wreg  in  REGW  EX/MEM destination.
- wb_regwrite  in  1  MEM/WB RegWrite.
- wb_wreg  in  REGW  MEM/WB destination.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register update enable.
- bubble  out  1  insert nop into ID/EX.
- pipe_en  out  1  whole-pipeline advance enable.
- imem_en  out  1  instruction memory request enable.
- fwd_sel  out  2*NREAD  per port: 0=regfile, 1=EX, 2=MEM, 3=WB.
- stall_count  out  CNTW  saturating count of bubble cycles.

Behaviour:
- Reset (rst=0, async): state=RUN, cnt=0, stall_count=0. Outputs while reset: pc_write=0, ifid_write=0, bubble=0, pipe_en=0, imem_en=0, fwd_sel=0.
- Forwarding is combinational, per port k:
  - EX match (ex_regwrite && !ex_memread && ex_wreg==rs_k) gives 1.
  - Else MEM match gives 2.
  - Else WB match gives 3.
  - Else 0.
  - No forwarding if rs_k==0 or !id_rs_used[k].
  - During a bubble cycle, fwd_sel is don't-care but still computed.
- Load-use detect (lu): ex_regwrite && ex_memread && ex_wreg!=0 && any used port with rs_k==ex_wreg.
- FSM states: RUN, LU_STALL, BR_FLUSH. cnt is a down-counter of width clog2(max(LOAD_USE_CYC,BR_BUBBLES))+1.
- RUN:
  - lu: bubble=1, pc_write=0, ifid_write=0, imem_en=0. If LOAD_USE_CYC>1, go to LU_STALL with cnt=LOAD_USE_CYC-1; otherwise stay in RUN.
  - else id_branch: bubble=1, pc_write=1, ifid_write=0, imem_en=1 (target prefetch). If BR_BUBBLES>1, go to BR_FLUSH with cnt=BR_BUBBLES-1.
  - else: all enables=1, bubble=0.
- lu has priority over id_branch in the same cycle. The branch is re-evaluated after the stall.
- LU_STALL: same outputs as the RUN-lu case. cnt decrements each advancing cycle; at cnt==1, return to RUN.
- BR_FLUSH: bubble=1, pc_write=0, ifid_write=0, imem_en=0. cnt decrements; at cnt==1, return to RUN.
- Waits: dmem_wait or imem_wait forces pipe_en=0, pc_write=0, ifid_write=0. imem_en=0 only when dmem_wait. bubble keeps its state-derived value. State, cnt and stall_count are frozen.
- enable=0: all enables 0, bubble=0, and state, cnt and stall_count are frozen. Resuming continues the interrupted stall or flush exactly.
- pipe_en=1 whenever enable=1 and no wait.
- stall_count increments on each advancing cycle with bubble=1 and saturates at all-ones.
- Reset asserted mid-stall aborts to RUN immediately.

Decomposition:
- hazard_pkg: fwd_sel encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), FSM state encodings, clog2 function.
- One sub-module, hazard_fwd_port: single-port comparator/priority encoder, instantiated NREAD times via generate.

Test Plan:
1. Port0 rs=3; ex_regwrite=1, ex_wreg=3, not a load; mem_wreg=3, wb_wreg=3, both writing -> fwd_sel[1:0]=1. Remove EX -> 2. Remove MEM -> 3. rs=0 with all stages writing reg 0 -> 0.
2. LOAD_USE_CYC=2; ex load writes r5; port1 reads r5 -> exactly 2 cycles with bubble=1, pc_write=0, ifid_write=0. Cycle 3 is RUN; stall_count increments by 2.
3. BR_BUBBLES=2; id_branch=1 -> cycle 1: bubble=1, pc_write=1, imem_en=1. Cycle 2: bubble=1, pc_write=0. Cycle 3: RUN.
4. Load-use and id_branch in the same cycle -> load-use outputs (pc_write=0); the branch is handled after the stall.
5. dmem_wait=1 for 3 cycles in the middle of LU_STALL -> pipe_en=0, imem_en=0, cnt held. The stall completes after the wait deasserts, with total bubbles unchanged.
6. rst pulsed low in BR_FLUSH -> outputs go to reset values immediately. stall_count=0. After release: RUN.
